// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: shared FSM encoding, DSO command opcodes and defaults for the host command master
package host_cmd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STRB, WAIT_TX, RESP, FIN} state_t;
  localparam logic [7:0] DUMP_CH  = 8'h01;
  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] TRIG_LVL = 8'h03;
  localparam logic [7:0] TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC  = 8'h05;
  localparam logic [7:0] TRIG_CFG = 8'h06;
  localparam logic [7:0] TRIG_RD  = 8'h07;
  localparam logic [7:0] EEP_WRT  = 8'h08;
  localparam logic [7:0] EEP_RD   = 8'h09;
  localparam logic [7:0] ACK      = 8'hA5;
  localparam int LEN_W_DEF        = 10;
  localparam int TO_CYCLES_DEF    = 1000000;
endpackage

// File: rtl/host_to_timer.sv
// host_to_timer: per-byte idle counter flagging expiry after TO_CYCLES enabled clocks
module host_to_timer import host_cmd_pkg::*; #(
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TO_CYCLES);
  logic [W-1:0] cnt;
  assign expired = en && !clr && cnt == W'(TO_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/host_cmd_mstr.sv
// host_cmd_mstr: serialises a multi-byte command to a UART and streams back the response bytes
module host_cmd_mstr import host_cmd_pkg::*; #(
  parameter int CMD_BYTES = 3,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*CMD_BYTES-1:0] cmd,
  input  logic [LEN_W-1:0]       resp_len,
  input  logic                   send_cmd,
  output logic                   busy,
  output logic                   cmd_sent,
  output logic [7:0]             resp_data,
  output logic                   resp_vld,
  input  logic                   resp_rdy,
  output logic                   done,
  output logic                   timeout,
  output logic                   overrun,
  output logic [7:0]             tx_data,
  output logic                   trmt,
  input  logic                   tx_done,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   clr_rx_rdy
);
  state_t state, nxt;
  logic [8*CMD_BYTES-1:0] shreg;
  logic [LEN_W-1:0] len, tx_cnt, rx_cnt;
  logic armed, tx_ok, last_tx, rx_take, to_clr, to_en, to_exp;
  assign busy    = state != IDLE;
  assign trmt    = state == STRB;
  assign done    = state == FIN;
  assign tx_ok   = state == WAIT_TX && armed && tx_done;
  assign last_tx = tx_ok && tx_cnt == LEN_W'(CMD_BYTES);
  assign rx_take = state == RESP && rx_rdy && !clr_rx_rdy && rx_cnt != len;
  assign to_clr  = !(state inside {WAIT_TX, RESP}) || tx_ok || rx_take;
  assign to_en   = state == WAIT_TX || (state == RESP && rx_cnt != len && !(resp_vld && !resp_rdy));
  host_to_timer #(.TO_CYCLES(TO_CYCLES)) u_to (
    .clk(clk), .rst_n(rst_n), .clr(to_clr), .en(to_en), .expired(to_exp)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = send_cmd ? LOAD : IDLE;
      LOAD:    nxt = STRB;
      STRB:    nxt = WAIT_TX;
      WAIT_TX: nxt = to_exp ? FIN : !tx_ok ? WAIT_TX : !last_tx ? LOAD : len != '0 ? RESP : FIN;
      RESP:    nxt = (to_exp || (rx_cnt == len && !resp_vld)) ? FIN : RESP;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      len        <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      armed      <= 1'b0;
      cmd_sent   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      tx_data    <= '0;
      resp_data  <= '0;
      resp_vld   <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= nxt;
      armed      <= state == WAIT_TX;
      cmd_sent   <= last_tx;
      clr_rx_rdy <= rx_rdy && !clr_rx_rdy;
      if (state == IDLE && send_cmd) begin
        shreg   <= cmd;
        len     <= resp_len;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
        timeout <= 1'b0;
        overrun <= 1'b0;
      end
      if (state == LOAD) tx_data <= shreg[8*CMD_BYTES-1 -: 8];
      if (state == STRB) begin
        shreg  <= shreg << 8;
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (to_exp) begin
        timeout  <= 1'b1;
        resp_vld <= 1'b0;
      end else if (rx_take) begin
        rx_cnt <= rx_cnt + 1'b1;
        if (!resp_vld || resp_rdy) begin
          resp_data <= rx_data;
          resp_vld  <= 1'b1;
        end else overrun <= 1'b1;
      end else if (resp_vld && resp_rdy) resp_vld <= 1'b0;
    end
endmodule

// File: tb/tb_host_cmd_mstr.sv
// tb_host_cmd_mstr: directed self-checking bench with a scripted UART model around host_cmd_mstr
module tb_host_cmd_mstr;
  import host_cmd_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] cmd = '0;
  logic [9:0] resp_len = '0;
  logic send_cmd = 1'b0, resp_rdy = 1'b0, tx_done = 1'b0, rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic busy, cmd_sent, resp_vld, done, timeout, overrun, trmt, clr_rx_rdy;
  logic [7:0] resp_data, tx_data;
  int checks = 0, failures = 0, n_cmd_sent = 0, tx_cd = 0;
  logic [7:0] txq[$], rxq[$];
  host_cmd_mstr #(.CMD_BYTES(3), .LEN_W(10), .TO_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .resp_len(resp_len), .send_cmd(send_cmd),
    .busy(busy), .cmd_sent(cmd_sent), .resp_data(resp_data), .resp_vld(resp_vld),
    .resp_rdy(resp_rdy), .done(done), .timeout(timeout), .overrun(overrun),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .rx_data(rx_data),
    .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (trmt) begin
      txq.push_back(tx_data);
      tx_done = 1'b0;
      tx_cd = 4;
    end else if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) tx_done = 1'b1;
    end
    if (resp_vld && resp_rdy) rxq.push_back(resp_data);
    if (cmd_sent) n_cmd_sent++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic start(input logic [23:0] c, input logic [9:0] l);
    tick();
    cmd = c;
    resp_len = l;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
  endtask
  task automatic send_rx(input logic [7:0] b);
    tick();
    rx_data = b;
    rx_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (clr_rx_rdy) break;
    end
    rx_rdy = 1'b0;
  endtask
  task automatic wait_cmd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cmd_sent) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask
  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask
  task automatic chk_tx(input string tag, input logic [23:0] c);
    chk({tag, "_txn"}, txq.size(), 3);
    for (int i = 0; i < 3; i++) chk({tag, "_txb"}, (i < txq.size()) ? 32'(txq[i]) : 32'hx, 32'(c[23-8*i -: 8]));
  endtask
  initial begin
    int n0, k, bad;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_vld", resp_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {timeout, overrun, cmd_sent, clr_rx_rdy}, 0);
    chk("rst_txd", tx_data, 0);
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    txq.delete(); rxq.delete(); n0 = n_cmd_sent;
    start({EEP_WRT, 8'h2A, 8'hBB}, 1);
    chk("t1_busy", busy, 1);
    chk("t1_trmt_early", trmt, 0);
    tick();
    chk("t1_trmt_lat", trmt, 1);
    chk("t1_txd0", tx_data, 32'(EEP_WRT));
    wait_cmd("t1_cmd_sent");
    send_rx(ACK);
    chk("t1_vld_lat", resp_vld, 1);
    chk("t1_data", resp_data, 32'(ACK));
    wait_done("t1_done");
    chk_tx("t1", {EEP_WRT, 8'h2A, 8'hBB});
    chk("t1_cmd_sent_cnt", n_cmd_sent - n0, 1);
    chk("t1_rxn", rxq.size(), 1);
    chk("t1_flags", {timeout, overrun}, 0);
    tick();
    chk("t1_idle", busy, 0);
    send_rx(8'h77);
    chk("stray_clr", clr_rx_rdy, 1);
    tick();
    chk("stray_vld", resp_vld, 0);
    chk("stray_flags", {busy, timeout, overrun}, 0);
    rxq.delete();
    start({DUMP_CH, 8'h00, 8'hFF}, 510);
    wait_cmd("t2_cmd_sent");
    for (int i = 0; i < 510; i++) send_rx(8'(i));
    wait_done("t2_done");
    chk("t2_rxn", rxq.size(), 510);
    bad = 0;
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== 8'(i)) bad++;
    chk("t2_order", bad, 0);
    chk("t2_flags", {timeout, overrun}, 0);
    rxq.delete();
    resp_rdy = 1'b0;
    start({TRIG_POS, 8'h12, 8'h34}, 3);
    wait_cmd("t3_cmd_sent");
    send_rx(8'h11);
    send_rx(8'h22);
    chk("t3_overrun", overrun, 1);
    chk("t3_vld", resp_vld, 1);
    chk("t3_hold", resp_data, 32'h11);
    resp_rdy = 1'b1;
    send_rx(8'h33);
    wait_done("t3_done");
    chk("t3_rxn", rxq.size(), 2);
    chk("t3_rx0", rxq.size() > 0 ? 32'(rxq[0]) : 32'hx, 32'h11);
    chk("t3_rx1", rxq.size() > 1 ? 32'(rxq[1]) : 32'hx, 32'h33);
    chk("t3_sticky", overrun, 1);
    start({EEP_RD, 8'h05, 8'h00}, 1);
    chk("t4_ovr_clr", overrun, 0);
    wait_cmd("t4_cmd_sent");
    k = 0;
    while (!timeout && k < 1100) begin
      tick();
      k++;
    end
    chk("t4_to_cycles", k, 1000);
    chk("t4_done", done, 1);
    chk("t4_vld", resp_vld, 0);
    tick();
    chk("t4_idle", busy, 0);
    chk("t4_sticky", timeout, 1);
    txq.delete(); n0 = n_cmd_sent;
    start({SET_DEC, 8'h00, 8'h03}, 0);
    chk("t5_to_clr", timeout, 0);
    repeat (3) tick();
    cmd = 24'hDEADBE;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
    wait_cmd("t5_cmd_sent");
    chk("t5_done", done, 1);
    tick();
    chk("t5_idle", {busy, done}, 0);
    chk_tx("t5", {SET_DEC, 8'h00, 8'h03});
    chk("t5_cmd_sent_cnt", n_cmd_sent - n0, 1);
    txq.delete(); rxq.delete();
    start({EEP_WRT, 8'h2A, 8'hBB}, 1);
    k = 0;
    while (!(trmt && txq.size() == 2) && k < 100) begin
      tick();
      k++;
    end
    chk("t6_reach", 32'(k < 100), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_abort", {trmt, busy, resp_vld}, 0);
    tick();
    rst_n = 1'b1;
    txq.delete();
    start({TRIG_LVL, 8'h80, 8'h00}, 1);
    wait_cmd("t6_cmd_sent");
    send_rx(ACK);
    wait_done("t6_done");
    chk_tx("t6", {TRIG_LVL, 8'h80, 8'h00});
    chk("t6_rx", rxq.size() == 1 ? 32'(rxq[0]) : 32'hx, 32'(ACK));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
